// File: rtl/async_toggle_sink.sv
// ---------------------------------------------------------------------------
// async_toggle_sink
//
// Receive-side endpoint of a toggle-handshake clock crossing.
//
// A request is a change of level on io_req_tog, which arrives already passed
// through a 3-flop synchronizer. When a new request is seen, the sink waits
// SETTLE cycles for the sender's quasi-static data bus to become safe to
// sample. It then captures the word and offers it on a ready/valid dequeue
// port. The ack toggle goes back to the sender only once the word has been
// dequeued, so at most one word is in flight.
//
// Ports
//   clock         receive-domain clock
//   reset         asynchronous active-low reset (0 = in reset)
//   io_req_tog    synchronized sender request toggle
//   io_data       sender data; stable from its toggle until our ack is seen
//   io_ack_tog    ack toggle to the sender domain (flop output, glitch-free)
//   io_deq_valid  captured word available
//   io_deq_ready  consumer accepts the word
//   io_deq_bits   captured word (flop output)
//   io_busy       a transfer is in progress (WAIT or VALID)
//   io_proto_err  sticky: the request toggled while a word was in flight
//   io_count      completed dequeues, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module async_toggle_sink #(
  parameter int W      = 32,
  parameter int SETTLE = 2,   // 0..15
  parameter int CNT_W  = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_req_tog,
  input  logic [W-1:0]     io_data,
  output logic             io_ack_tog,
  output logic             io_deq_valid,
  input  logic             io_deq_ready,
  output logic [W-1:0]     io_deq_bits,
  output logic             io_busy,
  output logic             io_proto_err,
  output logic [CNT_W-1:0] io_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t             state_q, state_d;
  logic               req_seen_q, req_seen_d;
  logic               ack_q, ack_d;
  logic [W-1:0]       bits_q, bits_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [3:0]         cnt_q, cnt_d;

  // A request is pending whenever the synchronized toggle differs from the
  // parity of the last request we accepted.
  logic new_req;
  assign new_req = io_req_tog ^ req_seen_q;

  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    bits_d     = bits_q;
    err_d      = err_q;
    count_d    = count_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (new_req) begin
          req_seen_d = io_req_tog;
          if (SETTLE == 0) begin
            bits_d  = io_data;
            state_d = VALID;
          end else begin
            cnt_d   = SETTLE_CNT;
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          bits_d  = io_data;
          state_d = VALID;
        end
        // req_seen is not updated while busy, so a mismatch stays pending and
        // is picked up as a fresh request once we are back in IDLE.
        if (new_req) begin
          err_d = 1'b1;
        end
      end

      VALID: begin
        if (new_req) begin
          err_d = 1'b1;
        end
        if (io_deq_ready) begin
          state_d = IDLE;
          ack_d   = ~ack_q;
          count_d = count_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      bits_q     <= '0;
      err_q      <= 1'b0;
      count_q    <= '0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      bits_q     <= bits_d;
      err_q      <= err_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
    end
  end

  assign io_ack_tog   = ack_q;
  assign io_deq_valid = (state_q == VALID);
  assign io_deq_bits  = bits_q;
  assign io_busy      = (state_q != IDLE);
  assign io_proto_err = err_q;
  assign io_count     = count_q;

endmodule

// File: tb/tb_async_toggle_sink.sv
// ---------------------------------------------------------------------------
// tb_async_toggle_sink
//
// Two instances share one clock and one reset:
//   index 0 : SETTLE=2, CNT_W=4
//   index 1 : SETTLE=0, CNT_W=16
// A transfer-level reference model tracks each instance: whether a word is
// in flight, the cycle its valid window opens, the captured word, the number
// of completed dequeues, and the sticky error. A word queue per instance
// checks that no word is lost or duplicated.
// ---------------------------------------------------------------------------
module tb_async_toggle_sink;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req     [2];
  logic [31:0] data    [2];
  logic        ready   [2];
  logic        ack_o   [2];
  logic        valid_o [2];
  logic [31:0] bits_o  [2];
  logic        busy_o  [2];
  logic        err_o   [2];
  logic [3:0]  cnt_a;
  logic [15:0] cnt_b;
  logic [31:0] cnt_o   [2];

  always_comb begin
    cnt_o[0] = {28'd0, cnt_a};
    cnt_o[1] = {16'd0, cnt_b};
  end

  async_toggle_sink #(.W(32), .SETTLE(2), .CNT_W(4)) u_dut_a (
    .clock(clk), .reset(rst_n),
    .io_req_tog(req[0]), .io_data(data[0]),
    .io_ack_tog(ack_o[0]), .io_deq_valid(valid_o[0]), .io_deq_ready(ready[0]),
    .io_deq_bits(bits_o[0]), .io_busy(busy_o[0]), .io_proto_err(err_o[0]),
    .io_count(cnt_a)
  );

  async_toggle_sink #(.W(32), .SETTLE(0), .CNT_W(16)) u_dut_b (
    .clock(clk), .reset(rst_n),
    .io_req_tog(req[1]), .io_data(data[1]),
    .io_ack_tog(ack_o[1]), .io_deq_valid(valid_o[1]), .io_deq_ready(ready[1]),
    .io_deq_bits(bits_o[1]), .io_busy(busy_o[1]), .io_proto_err(err_o[1]),
    .io_count(cnt_b)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [31:0] sq0[$];
  logic [31:0] sq1[$];

  function automatic void sb_push(input int i, input logic [31:0] w);
    if (i == 0) sq0.push_back(w);
    else        sq1.push_back(w);
  endfunction

  function automatic int sb_size(input int i);
    return (i == 0) ? sq0.size() : sq1.size();
  endfunction

  function automatic logic [31:0] sb_pop(input int i);
    if (i == 0) return sq0.pop_front();
    return sq1.pop_front();
  endfunction

  // ---------------- reference model ----------------
  int          cyc;
  bit          m_busy  [2];
  bit          m_seen  [2];
  int          m_vat   [2];   // index of the edge after which valid is high
  logic [31:0] m_bits  [2];
  int          m_fires [2];
  bit          m_err   [2];

  function automatic int settle_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic bit m_vis(input int i);
    return m_busy[i] && (cyc >= m_vat[i]);
  endfunction

  function automatic logic [31:0] m_count(input int i);
    return (i == 0) ? 32'(m_fires[i] % 16) : 32'(m_fires[i] % 65536);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int i = 0; i < 2; i++) begin
        m_busy[i]  <= 1'b0;
        m_seen[i]  <= 1'b0;
        m_vat[i]   <= 0;
        m_bits[i]  <= 32'd0;
        m_fires[i] <= 0;
        m_err[i]   <= 1'b0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
        if (m_busy[i] && (req[i] != m_seen[i])) m_err[i] <= 1'b1;
        if (m_vis(i) && ready[i]) begin
          m_busy[i]  <= 1'b0;
          m_fires[i] <= m_fires[i] + 1;
        end else if (!m_busy[i] && (req[i] != m_seen[i])) begin
          m_busy[i] <= 1'b1;
          m_seen[i] <= req[i];
          m_vat[i]  <= cyc + 1 + settle_of(i);
          if (settle_of(i) == 0) m_bits[i] <= data[i];
        end else if (m_busy[i] && (cyc + 1 == m_vat[i])) begin
          m_bits[i] <= data[i];
        end
      end
    end
  end

  // Continuous comparison, sampled after the inputs settle on the falling edge.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check_eq($sformatf("valid%0d", i), 32'(valid_o[i]), 32'(m_vis(i)));
        check_eq($sformatf("busy%0d", i),  32'(busy_o[i]),  32'(m_busy[i]));
        check_eq($sformatf("bits%0d", i),  bits_o[i],       m_bits[i]);
        check_eq($sformatf("ack%0d", i),   32'(ack_o[i]),   32'(m_fires[i] % 2));
        check_eq($sformatf("count%0d", i), cnt_o[i],        m_count(i));
        check_eq($sformatf("err%0d", i),   32'(err_o[i]),   32'(m_err[i]));
        if (rst_n && valid_o[i] && ready[i]) begin
          if (sb_size(i) > 0) check_eq($sformatf("sb_word%0d", i), bits_o[i], sb_pop(i));
          else                check_eq($sformatf("sb_extra%0d", i), 32'(valid_o[i]), 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic do_reset_async();
    #2;
    rst_n  = 1'b0;
    req[0] = 1'b0;
    req[1] = 1'b0;
    sq0.delete();
    sq1.delete();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_valid%0d", i), 32'(valid_o[i]), 32'd0);
      check_eq($sformatf("rst_busy%0d", i),  32'(busy_o[i]),  32'd0);
      check_eq($sformatf("rst_ack%0d", i),   32'(ack_o[i]),   32'd0);
      check_eq($sformatf("rst_bits%0d", i),  bits_o[i],       32'd0);
      check_eq($sformatf("rst_err%0d", i),   32'(err_o[i]),   32'd0);
      check_eq($sformatf("rst_count%0d", i), cnt_o[i],        32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input int i, input logic [31:0] w);
    int t = 0;
    while (ack_o[i] !== req[i] && t < 100) begin
      @(negedge clk);
      t++;
    end
    check_eq($sformatf("send_ack%0d", i), 32'(ack_o[i]), 32'(req[i]));
    data[i] = w;
    req[i]  = ~req[i];
    sb_push(i, w);
  endtask

  task automatic wait_valid(input int i, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid_o[i] && n < 50);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int n;
    logic [31:0] w;

    req[0] = 1'b0;  req[1] = 1'b0;
    data[0] = 32'd0; data[1] = 32'd0;
    ready[0] = 1'b0; ready[1] = 1'b0;
    @(negedge clk);
    do_reset_async();
    chk_en = 1'b1;

    // 1: SETTLE=2 latency and first transfer
    ready[0] = 1'b1;
    send(0, 32'hDEADBEEF);
    wait_valid(0, n);
    check_eq("t1_latency", 32'(n), 32'd3);
    check_eq("t1_bits", bits_o[0], 32'hDEADBEEF);
    @(negedge clk);
    check_eq("t1_ack", 32'(ack_o[0]), 32'd1);
    check_eq("t1_count", cnt_o[0], 32'd1);

    // 2: backpressure
    ready[0] = 1'b0;
    send(0, 32'h12345678);
    wait_valid(0, n);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq("t2_hold_valid", 32'(valid_o[0]), 32'd1);
      check_eq("t2_hold_bits", bits_o[0], 32'h12345678);
      check_eq("t2_hold_ack", 32'(ack_o[0]), 32'd1);
    end
    ready[0] = 1'b1;
    @(negedge clk);
    check_eq("t2_ack_flip", 32'(ack_o[0]), 32'd0);
    @(negedge clk);
    check_eq("t2_ack_once", 32'(ack_o[0]), 32'd0);
    check_eq("t2_count", cnt_o[0], 32'd2);

    // 3: SETTLE=0 latency, data change after capture
    ready[1] = 1'b0;
    send(1, 32'hA5A50001);
    wait_valid(1, n);
    check_eq("t3_latency", 32'(n), 32'd1);
    data[1] = 32'h0F0F0F0F;
    repeat (2) @(negedge clk);
    check_eq("t3_bits_held", bits_o[1], 32'hA5A50001);
    ready[1] = 1'b1;
    @(negedge clk);
    check_eq("t3_ack", 32'(ack_o[1]), 32'd1);

    // 4: protocol error while VALID
    ready[0] = 1'b0;
    send(0, 32'h11110000);
    wait_valid(0, n);
    data[0] = 32'h22220000;
    req[0]  = ~req[0];
    sb_push(0, 32'h22220000);
    @(negedge clk);
    check_eq("t4_err", 32'(err_o[0]), 32'd1);
    check_eq("t4_bits", bits_o[0], 32'h11110000);
    ready[0] = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("t4_err_sticky", 32'(err_o[0]), 32'd1);
    check_eq("t4_count", cnt_o[0], 32'd4);
    check_eq("t4_drained", 32'(sb_size(0)), 32'd0);
    do_reset_async();

    // 5: reset in WAIT, reset in VALID, then normal acceptance
    ready[0] = 1'b0;
    send(0, 32'hCAFE0001);
    @(negedge clk);
    check_eq("t5_in_wait", 32'(busy_o[0]), 32'd1);
    do_reset_async();
    send(0, 32'hCAFE0002);
    wait_valid(0, n);
    check_eq("t5_in_valid", 32'(valid_o[0]), 32'd1);
    do_reset_async();
    ready[0] = 1'b1;
    send(0, 32'hCAFE0003);
    wait_valid(0, n);
    check_eq("t5_latency", 32'(n), 32'd3);
    @(negedge clk);
    check_eq("t5_ack", 32'(ack_o[0]), 32'd1);
    do_reset_async();

    // 6: 17 back-to-back transfers through the 4-bit counter
    ready[0] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      send(0, $urandom);
    end
    repeat (8) @(negedge clk);
    check_eq("t6_count", cnt_o[0], 32'd1);
    check_eq("t6_ack", 32'(ack_o[0]), 32'd1);
    check_eq("t6_drained", 32'(sb_size(0)), 32'd0);

    // Random traffic on both instances with random backpressure
    repeat (200) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        ready[i] = ($urandom_range(0, 3) != 0);
        if (ack_o[i] == req[i] && $urandom_range(0, 1) == 1) begin
          w       = $urandom;
          data[i] = w;
          req[i]  = ~req[i];
          sb_push(i, w);
        end
      end
    end
    ready[0] = 1'b1;
    ready[1] = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("rnd_drained0", 32'(sb_size(0)), 32'd0);
    check_eq("rnd_drained1", 32'(sb_size(1)), 32'd0);
    check_eq("rnd_err0", 32'(err_o[0]), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500000 time units");
    $fatal(1, "simulation time limit reached");
  end

endmodule
